// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the register-file control unit.
//   - Instruction field positions and widths.
//   - Opcode values and ALUOP encodings.
//   - FSM state type and the decoded control-vector struct.
package cpu_ctrl_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned OPCODE_W   = 8;
    localparam int unsigned INSTR_W    = 32;

    // Instruction layout: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm
    localparam int unsigned OPCODE_LSB = 24;
    localparam int unsigned DEST_LSB   = 16;
    localparam int unsigned SRC1_LSB   = 8;
    localparam int unsigned SRC2_LSB   = 0;

    localparam logic [OPCODE_W-1:0] OP_LOADI = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_MOV   = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_AND   = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_OR    = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_J     = 8'h06;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 8'h07;
    localparam logic [OPCODE_W-1:0] OP_LWD   = 8'h08;
    localparam logic [OPCODE_W-1:0] OP_LWI   = 8'h09;
    localparam logic [OPCODE_W-1:0] OP_SWD   = 8'h0A;
    localparam logic [OPCODE_W-1:0] OP_SWI   = 8'h0B;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef struct packed {
        logic [2:0] aluop;
        logic       neg_sel;
        logic       imm_sel;
        logic       reg_write;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       legal;
    } ctrl_vec_t;

endpackage

// File: rtl/reg_ctrl_unit_if.sv
// Bus between fetch/PC logic, register file/ALU/data memory and the control unit.
//   master : drives instruction, instr_valid, busywait (fetch + memory side)
//   slave  : the control unit; drives handshake ready and all control outputs
// When ILLEGAL_OP_TRAP_EN is defined the sticky illegal_op flag is also carried.
interface reg_ctrl_unit_if;

    logic [cpu_ctrl_pkg::INSTR_W-1:0]    instruction;
    logic                                instr_valid;
    logic                                instr_ready;
    logic                                busywait;
    logic [cpu_ctrl_pkg::REG_ADDR_W-1:0] inaddress;
    logic [cpu_ctrl_pkg::REG_ADDR_W-1:0] out1address;
    logic [cpu_ctrl_pkg::REG_ADDR_W-1:0] out2address;
    logic                                write;
    logic [cpu_ctrl_pkg::DATA_W-1:0]     immediate;
    logic [cpu_ctrl_pkg::DATA_W-1:0]     offset;
    logic [2:0]                          aluop;
    logic                                neg_sel;
    logic                                imm_sel;
    logic                                wb_sel;
    logic                                jump;
    logic                                branch;
    logic                                mem_read;
    logic                                mem_write;
    logic                                pc_stall;
`ifdef ILLEGAL_OP_TRAP_EN
    logic                                illegal_op;
`endif

    modport master (
        output instruction, instr_valid, busywait,
        input  instr_ready, inaddress, out1address, out2address, write, immediate, offset,
               aluop, neg_sel, imm_sel, wb_sel, jump, branch, mem_read, mem_write, pc_stall
`ifdef ILLEGAL_OP_TRAP_EN
        , input illegal_op
`endif
    );

    modport slave (
        input  instruction, instr_valid, busywait,
        output instr_ready, inaddress, out1address, out2address, write, immediate, offset,
               aluop, neg_sel, imm_sel, wb_sel, jump, branch, mem_read, mem_write, pc_stall
`ifdef ILLEGAL_OP_TRAP_EN
        , output illegal_op
`endif
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode -> control-vector decoder.
//   i_opcode : instruction opcode field
//   o_ctrl   : ALU/mux selects, strobe classes and a legal flag (0 for opcodes > 0x0B,
//              in which case every other field is 0)
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_vec_t           o_ctrl
);

    always_comb begin
        o_ctrl       = '0;
        o_ctrl.legal = 1'b1;
        case (i_opcode)
            OP_LOADI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.imm_sel   = 1'b1;
            end
            OP_MOV: o_ctrl.reg_write = 1'b1;
            OP_ADD: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.aluop     = ALU_ADD;
            end
            OP_SUB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.aluop     = ALU_ADD;
                o_ctrl.neg_sel   = 1'b1;
            end
            OP_AND: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.aluop     = ALU_AND;
            end
            OP_OR: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.aluop     = ALU_OR;
            end
            OP_J: o_ctrl.jump = 1'b1;
            // BEQ subtracts so the PC logic can test the ALU zero flag
            OP_BEQ: begin
                o_ctrl.branch  = 1'b1;
                o_ctrl.aluop   = ALU_ADD;
                o_ctrl.neg_sel = 1'b1;
            end
            OP_LWD: o_ctrl.mem_read = 1'b1;
            OP_LWI: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.imm_sel  = 1'b1;
            end
            OP_SWD: o_ctrl.mem_write = 1'b1;
            OP_SWI: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.imm_sel   = 1'b1;
            end
            default: o_ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_ctrl_unit.sv
// Decode/control FSM for the 8x8 register file, ALU and data memory.
//   i_clk   : clock, all state on posedge
//   i_reset : synchronous active-high reset
//   bus     : reg_ctrl_unit_if.slave (instruction handshake, busywait, all control outputs)
// Every output is a register loaded from the next state and the next latched instruction,
// so outputs describe the state the unit is in during the current cycle.
// Build option ILLEGAL_OP_TRAP_EN: illegal opcodes set sticky illegal_op and halt the unit
// until reset; without it they run as a one-cycle NOP.
module reg_ctrl_unit
    import cpu_ctrl_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset,
    reg_ctrl_unit_if.slave bus
);

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e                r_state;
    state_e                w_state_d;
    logic [INSTR_W-1:0]    r_instr;
    logic [INSTR_W-1:0]    w_instr_d;
    logic                  r_mem_first;
    logic                  w_accept;
    ctrl_vec_t             w_ctrl;
    logic                  w_exec;
    logic                  w_mem;
    logic                  w_wb;

    logic                  r_ready;
    logic                  r_write;
    logic                  r_jump;
    logic                  r_branch;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_pc_stall;
    logic                  r_wb_sel;
    logic                  r_neg_sel;
    logic                  r_imm_sel;
    logic [2:0]            r_aluop;
    logic [REG_ADDR_W-1:0] r_inaddr;
    logic [REG_ADDR_W-1:0] r_out1addr;
    logic [REG_ADDR_W-1:0] r_out2addr;
    logic [DATA_W-1:0]     r_imm;
    logic [DATA_W-1:0]     r_offset;

    assign w_accept  = bus.instr_valid & r_ready;
    // Decode the incoming word on accept, otherwise the latched one
    assign w_instr_d = w_accept ? bus.instruction : r_instr;

    ctrl_decode u_decode (
        .i_opcode (w_instr_d[OPCODE_LSB +: OPCODE_W]),
        .o_ctrl   (w_ctrl)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StExec: begin
                if (!w_accept) begin
                    w_state_d = StIdle;
                end else if (TRAP_EN && !w_ctrl.legal) begin
                    w_state_d = StHalt;
                end else if (w_ctrl.mem_read || w_ctrl.mem_write) begin
                    w_state_d = StMem;
                end else begin
                    w_state_d = StExec;
                end
            end
            StMem: begin
                // busywait is ignored in the first MEM cycle
                if (!r_mem_first && !bus.busywait) begin
                    w_state_d = w_ctrl.mem_read ? StWb : StIdle;
                end
            end
            StWb:    w_state_d = StIdle;
            StHalt:  w_state_d = StHalt;
            default: w_state_d = StIdle;
        endcase
    end

    assign w_exec = (w_state_d == StExec);
    assign w_mem  = (w_state_d == StMem);
    assign w_wb   = (w_state_d == StWb);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_instr     <= '0;
            r_mem_first <= 1'b0;
            r_ready     <= 1'b1;
            r_write     <= 1'b0;
            r_jump      <= 1'b0;
            r_branch    <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_pc_stall  <= 1'b0;
            r_wb_sel    <= 1'b0;
            r_neg_sel   <= 1'b0;
            r_imm_sel   <= 1'b0;
            r_aluop     <= ALU_FWD;
            r_inaddr    <= '0;
            r_out1addr  <= '0;
            r_out2addr  <= '0;
            r_imm       <= '0;
            r_offset    <= '0;
        end else begin
            r_state     <= w_state_d;
            r_instr     <= w_instr_d;
            r_mem_first <= (r_state != StMem) && w_mem;
            r_ready     <= (w_state_d == StIdle) || w_exec;
            r_write     <= (w_exec && w_ctrl.reg_write) || w_wb;
            r_jump      <= w_exec && w_ctrl.jump;
            r_branch    <= w_exec && w_ctrl.branch;
            r_mem_read  <= w_mem && w_ctrl.mem_read;
            r_mem_write <= w_mem && w_ctrl.mem_write;
            r_pc_stall  <= w_mem;
            r_wb_sel    <= w_wb;
            // ALU selects only meaningful while an instruction is executing or in memory
            r_neg_sel   <= (w_exec || w_mem) && w_ctrl.neg_sel;
            r_imm_sel   <= (w_exec || w_mem) && w_ctrl.imm_sel;
            r_aluop     <= (w_exec || w_mem) ? w_ctrl.aluop : ALU_FWD;
            r_inaddr    <= w_instr_d[DEST_LSB +: REG_ADDR_W];
            r_out1addr  <= w_instr_d[SRC1_LSB +: REG_ADDR_W];
            r_out2addr  <= w_instr_d[SRC2_LSB +: REG_ADDR_W];
            r_imm       <= w_instr_d[SRC2_LSB +: DATA_W];
            r_offset    <= w_instr_d[DEST_LSB +: DATA_W];
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic r_illegal_op;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_illegal_op <= 1'b0;
        end else if (w_accept && !w_ctrl.legal) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign bus.illegal_op = r_illegal_op;
`endif

    assign bus.instr_ready = r_ready;
    assign bus.write       = r_write;
    assign bus.jump        = r_jump;
    assign bus.branch      = r_branch;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.pc_stall    = r_pc_stall;
    assign bus.wb_sel      = r_wb_sel;
    assign bus.neg_sel     = r_neg_sel;
    assign bus.imm_sel     = r_imm_sel;
    assign bus.aluop       = r_aluop;
    assign bus.inaddress   = r_inaddr;
    assign bus.out1address = r_out1addr;
    assign bus.out2address = r_out2addr;
    assign bus.immediate   = r_imm;
    assign bus.offset      = r_offset;

endmodule

// File: tb/tb_reg_ctrl_unit.sv
// Bench for reg_ctrl_unit: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level model of the unit.
module tb_reg_ctrl_unit;

    logic clk = 1'b0;
    logic rst;

    reg_ctrl_unit_if bus_if ();

    reg_ctrl_unit dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1 executing, 2 memory access, 3 load writeback, 4 halted
    typedef struct {
        int          ph;
        logic [31:0] ins;
        bit          first;
        bit          ill;
    } mstate_t;

    mstate_t m;
    bit      m_live = 1'b0;

    function automatic mstate_t model_next(mstate_t s, bit valid, logic [31:0] instr, bit bw);
        mstate_t n = s;
        int      op;
        if (s.ph <= 1) begin
            if (valid) begin
                n.ins = instr;
                op    = int'(instr[31:24]);
                if (op > 11 && TRAP) begin
                    n.ph  = 4;
                    n.ill = 1'b1;
                end else if (op >= 8 && op <= 11) begin
                    n.ph    = 2;
                    n.first = 1'b1;
                end else begin
                    n.ph = 1;
                end
            end else begin
                n.ph = 0;
            end
        end else if (s.ph == 2) begin
            op      = int'(s.ins[31:24]);
            n.first = 1'b0;
            if (!s.first && !bw) n.ph = (op == 8 || op == 9) ? 3 : 0;
        end else if (s.ph == 3) begin
            n.ph = 0;
        end
        return n;
    endfunction

    // {ill, ready, write, jump, branch, mem_rd, mem_wr, stall, wb_sel, neg, imm_sel,
    //  aluop[3], inaddr[3], out1[3], out2[3], imm[8], offset[8]}
    function automatic logic [38:0] exp_out(mstate_t s);
        int         op = int'(s.ins[31:24]);
        bit         act = (s.ph == 1 || s.ph == 2);
        logic [2:0] alu;
        bit         neg, imm;
        case (op)
            2, 3, 7: alu = 3'd1;
            4:       alu = 3'd2;
            5:       alu = 3'd3;
            default: alu = 3'd0;
        endcase
        neg = (op == 3 || op == 7);
        imm = (op == 0 || op == 9 || op == 11);
        if (!act) begin
            alu = 3'd0;
            neg = 1'b0;
            imm = 1'b0;
        end
        return {s.ill, (s.ph <= 1), ((s.ph == 1 && op <= 5) || s.ph == 3),
                (s.ph == 1 && op == 6), (s.ph == 1 && op == 7),
                (s.ph == 2 && (op == 8 || op == 9)), (s.ph == 2 && (op == 10 || op == 11)),
                (s.ph == 2), (s.ph == 3), neg, imm, alu,
                s.ins[18:16], s.ins[10:8], s.ins[2:0], s.ins[7:0], s.ins[23:16]};
    endfunction

    function automatic logic [38:0] act_out();
        logic ill;
`ifdef ILLEGAL_OP_TRAP_EN
        ill = bus_if.illegal_op;
`else
        ill = 1'b0;
`endif
        return {ill, bus_if.instr_ready, bus_if.write, bus_if.jump, bus_if.branch,
                bus_if.mem_read, bus_if.mem_write, bus_if.pc_stall, bus_if.wb_sel,
                bus_if.neg_sel, bus_if.imm_sel, bus_if.aluop, bus_if.inaddress,
                bus_if.out1address, bus_if.out2address, bus_if.immediate, bus_if.offset};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m      <= '{ph: 0, ins: 32'h0, first: 1'b0, ill: 1'b0};
            m_live <= 1'b1;
        end else if (m_live) begin
            m <= model_next(m, bus_if.instr_valid, bus_if.instruction, bus_if.busywait);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            n_checks++;
            if (act_out() !== exp_out(m)) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t: got %h want %h", $time, act_out(), exp_out(m));
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [31:0] instr, bit valid);
        bus_if.instruction = instr;
        bus_if.instr_valid = valid;
    endtask

    logic [31:0] rnd;
    logic [7:0]  rop;

    initial begin
        rst = 1'b1;
        bus_if.busywait = 1'b0;
        drive(32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(act_out()), 64'h20_0000_0000);
        rst = 1'b0;

        // LOADI r2,#5
        drive(32'h0002_0005, 1'b1);
        @(negedge clk);
        chk("loadi_write", bus_if.write, 1);
        chk("loadi_inaddr", bus_if.inaddress, 2);
        chk("loadi_imm_sel", bus_if.imm_sel, 1);
        chk("loadi_aluop", bus_if.aluop, 0);
        chk("loadi_immediate", bus_if.immediate, 8'h05);
        drive(32'h0, 1'b0);
        @(negedge clk);
        chk("loadi_write_drop", bus_if.write, 0);

        // ADD r3,r1,r2 ; SUB r4,r3,r1 ; J +8 ; BEQ -4 back-to-back
        drive(32'h0203_0102, 1'b1);
        @(negedge clk);
        chk("add_write", bus_if.write, 1);
        chk("add_alu", {bus_if.aluop, bus_if.neg_sel}, {3'd1, 1'b0});
        drive(32'h0304_0301, 1'b1);
        @(negedge clk);
        chk("sub_write", bus_if.write, 1);
        chk("sub_neg_alu", {bus_if.neg_sel, bus_if.aluop}, {1'b1, 3'd1});
        chk("sub_addr", {bus_if.out1address, bus_if.inaddress}, {3'd3, 3'd4});
        drive(32'h0608_0000, 1'b1);
        @(negedge clk);
        chk("j_strobes", {bus_if.jump, bus_if.branch, bus_if.write}, 3'b100);
        chk("j_offset", bus_if.offset, 8'h08);
        drive(32'h07FC_0102, 1'b1);
        @(negedge clk);
        chk("beq_strobes", {bus_if.jump, bus_if.branch, bus_if.write, bus_if.neg_sel}, 4'b0101);
        drive(32'h0, 1'b0);
        @(negedge clk);

        // LWD r5,r1 with busywait high across three edges
        drive(32'h0805_0001, 1'b1);
        bus_if.busywait = 1'b1;
        @(negedge clk);
        chk("lwd_mem0", {bus_if.mem_read, bus_if.pc_stall, bus_if.instr_ready}, 3'b110);
        drive(32'h0, 1'b0);
        @(negedge clk);
        chk("lwd_mem1", {bus_if.mem_read, bus_if.pc_stall, bus_if.write}, 3'b110);
        @(negedge clk);
        chk("lwd_mem2", {bus_if.mem_read, bus_if.pc_stall, bus_if.instr_ready}, 3'b110);
        bus_if.busywait = 1'b0;
        @(negedge clk);
        chk("lwd_wb", {bus_if.write, bus_if.wb_sel, bus_if.mem_read, bus_if.pc_stall,
                       bus_if.instr_ready}, 5'b11000);
        chk("lwd_wb_addr", bus_if.inaddress, 5);
        @(negedge clk);
        chk("lwd_done", {bus_if.write, bus_if.instr_ready}, 2'b01);

        // SWI r1,#0x10 with reset in the 2nd busywait cycle
        drive(32'h0B00_0110, 1'b1);
        bus_if.busywait = 1'b1;
        @(negedge clk);
        chk("swi_mem0", {bus_if.mem_write, bus_if.imm_sel, bus_if.out1address}, {2'b11, 3'd1});
        drive(32'h0, 1'b0);
        @(negedge clk);
        chk("swi_mem1", bus_if.mem_write, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("swi_reset", {bus_if.mem_write, bus_if.write, bus_if.pc_stall, bus_if.instr_ready},
            4'b0001);
        rst = 1'b0;
        bus_if.busywait = 1'b0;

        // Illegal opcode 0xFF
        drive(32'hFF00_0000, 1'b1);
        @(negedge clk);
        chk("ill_strobes", {bus_if.write, bus_if.jump, bus_if.branch, bus_if.mem_read,
                            bus_if.mem_write}, 5'b0);
        chk("ill_ready", bus_if.instr_ready, !TRAP);
        drive(32'h0201_0203, 1'b1);
        @(negedge clk);
        chk("ill_next_write", bus_if.write, !TRAP);
`ifdef ILLEGAL_OP_TRAP_EN
        chk("ill_sticky", {bus_if.illegal_op, bus_if.instr_ready}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("ill_cleared", {bus_if.illegal_op, bus_if.instr_ready}, 2'b01);
        rst = 1'b0;
`endif

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            bus_if.busywait = ($urandom_range(0, 2) != 0);
            rnd = $urandom;
            rop = 8'($urandom_range(0, 11));
            if ($urandom_range(0, 24) == 0) rop = 8'($urandom_range(12, 255));
            drive({rop, rnd[23:0]}, $urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
